// File: rtl/isochronous_hs_arb_pkg.sv
// Shared types and helpers for the isochronous handshake round-robin arbiter.
package isochronous_hs_arb_pkg;

    // Arbiter FSM: IDLE picks a requester, LOCKED holds the grant until accepted.
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Index width for n requesters; a single requester still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/isochronous_hs_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after ptr,
// wrapping modulo NumReq.
module isochronous_hs_rr_pick
    import isochronous_hs_arb_pkg::*;
#(
    parameter  int NumReq   = 4,
    localparam int IdxWidth = idx_width(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [IdxWidth-1:0] idx,
    output logic                any
);

    localparam logic [IdxWidth:0] NUM_REQ_W = (IdxWidth+1)'(NumReq);

    logic [2*NumReq-1:0] req_dbl;
    logic [NumReq-1:0]   req_rot;
    logic [IdxWidth-1:0] off;
    logic [IdxWidth:0]   sum;

    // Rotate so that bit 0 of req_rot is the requester sitting at ptr.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NumReq-1:0];
    assign any     = |req;

    // Lowest set offset in the rotated vector wins; scan downwards so it lands last.
    always_comb begin
        off = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                off = IdxWidth'(k);
            end
        end
    end

    // Undo the rotation: ptr + off folded back into 0..NumReq-1.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end
        idx = sum[IdxWidth-1:0];
    end

endmodule

// File: rtl/isochronous_hs_rr_arbiter.sv
// Round-robin arbiter in front of an isochronous 4-phase handshake source port.
// The grant is locked until the crossing accepts, so hs_valid_o/hs_idx_o stay
// stable as the crossing requires.
// Optional watchdog: define ISO_HS_ARB_TIMEOUT_EN to build the sticky timeout flag.
module isochronous_hs_rr_arbiter
    import isochronous_hs_arb_pkg::*;
#(
    parameter  int NumReq        = 4,
    parameter  int TimeoutCycles = 256,
    localparam int IdxWidth      = idx_width(NumReq)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_valid_i,
    output logic [NumReq-1:0]   req_ready_o,
    output logic                hs_valid_o,
    input  logic                hs_ready_i,
    output logic [IdxWidth-1:0] hs_idx_o,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam logic [IdxWidth-1:0] LAST_IDX = IdxWidth'(NumReq - 1);

    arb_state_e          state_reg, state_next;
    logic [IdxWidth-1:0] ptr_reg, ptr_next;
    logic [IdxWidth-1:0] idx_reg, idx_next;
    logic [IdxWidth-1:0] pick_idx;
    logic                pick_any;
    logic                locked;
    logic                xfer;

    isochronous_hs_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .req (req_valid_i),
        .ptr (ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign locked = (state_reg == ARB_LOCKED);
    assign xfer   = locked && hs_ready_i;

    // Next-state logic: grant in IDLE, release and advance the pointer on transfer.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    idx_next   = pick_idx;
                    state_next = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (hs_ready_i) begin
                    ptr_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // FSM, pointer and grant registers; reset drops any pending grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ARB_IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
        end
    end

    assign hs_valid_o = locked;
    assign busy_o     = locked;
    assign hs_idx_o   = locked ? idx_reg : '0;

    // Only the granted requester sees ready, and only while the crossing accepts.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
        assign req_ready_o[gi] = xfer && (idx_reg == IdxWidth'(gi));
    end

`ifdef ISO_HS_ARB_TIMEOUT_EN
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CNT_MAX = CntWidth'(TimeoutCycles);

    logic [CntWidth-1:0] cnt_reg, cnt_next;
    logic                timeout_reg, timeout_next;

    // Count stalled LOCKED cycles, saturating; the flag is sticky until reset.
    always_comb begin
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
        if (xfer) begin
            cnt_next = '0;
        end else if (locked && !hs_ready_i && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
        if (cnt_next == CNT_MAX) begin
            timeout_next = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout_o = timeout_reg;
`else
    assign timeout_o = 1'b0;
`endif

`ifndef SYNTHESIS
    // A requester must hold valid until its grant is accepted.
    property p_req_held;
        @(posedge clk_i) disable iff (!rst_ni)
            locked |-> req_valid_i[idx_reg];
    endproperty
    a_req_held : assert property (p_req_held)
        else $error("requester %0d dropped valid while granted", idx_reg);
`endif

endmodule

// File: tb/tb_isochronous_hs_rr_arbiter.sv
// Directed testbench for isochronous_hs_rr_arbiter (NumReq=4, TimeoutCycles=8).
module tb_isochronous_hs_rr_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] req_valid_i;
    logic [3:0] req_ready_o;
    logic       hs_valid_o;
    logic       hs_ready_i;
    logic [1:0] hs_idx_o;
    logic       busy_o;
    logic       timeout_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] obs;
    logic [7:0] exp_v;

    isochronous_hs_rr_arbiter #(
        .NumReq        (4),
        .TimeoutCycles (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .hs_valid_o  (hs_valid_o),
        .hs_ready_i  (hs_ready_i),
        .hs_idx_o    (hs_idx_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_valid_i = 4'b0000;
        hs_ready_i  = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    // obs/exp_v layout: {hs_valid, busy, hs_idx[1:0], req_ready[3:0]}
    task automatic test_reset();
        rst_ni      = 1'b0;
        req_valid_i = 4'b1111;
        hs_ready_i  = 1'b1;
        tick();
        tick();
        obs = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
        n_checks++;
        if (obs !== 8'b0000_0000 || timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b to=%b want 00000000 to=0", obs, timeout_o);
        end
        hs_ready_i = 1'b0;
        rst_ni     = 1'b1;
        tick();
        obs = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
        n_checks++;
        if (obs !== {1'b1, 1'b1, 2'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b want 11000000", obs);
        end
        $display("test_reset: first grant idx=%0d", hs_idx_o);
    endtask

    task automatic test_rr_fairness();
        logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req_valid_i = 4'b1111;
        hs_ready_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            obs   = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
            exp_v = {1'b1, 1'b1, seq[i], 4'b0001 << seq[i]};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", i, obs, exp_v);
            end
            tick();
            obs = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
            n_checks++;
            if (obs !== 8'b0000_0000) begin
                n_fail++;
                $display("FAIL rr_bubble[%0d]: got %b want 00000000", i, obs);
            end
            $display("test_rr_fairness: transfer %0d idx=%0d", i, seq[i]);
        end
        req_valid_i = 4'b0000;
        hs_ready_i  = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid_i = 4'b0100;
        hs_ready_i  = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            obs = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
            n_checks++;
            if (obs !== {1'b1, 1'b1, 2'd2, 4'b0000}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %b want 11100000", i, obs);
            end
            tick();
        end
        hs_ready_i = 1'b1;
        #1;
        obs = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
        n_checks++;
        if (obs !== {1'b1, 1'b1, 2'd2, 4'b0100}) begin
            n_fail++;
            $display("FAIL bp_accept: got %b want 11100100", obs);
        end
        tick();
        req_valid_i = 4'b0000;
        hs_ready_i  = 1'b0;
        tick();
        obs = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
        n_checks++;
        if (obs !== 8'b0000_0000) begin
            n_fail++;
            $display("FAIL bp_single: got %b want 00000000", obs);
        end
        $display("test_backpressure: idx 2 held 10 cycles then one transfer");
    endtask

    task automatic test_wrap_skip();
        logic [3:0] reqs [5] = '{4'b0100, 4'b0010, 4'b1111, 4'b1000, 4'b1111};
        logic [1:0] idxs [5] = '{2'd2,   2'd1,    2'd2,    2'd3,    2'd0};
        do_reset();
        hs_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid_i = reqs[i];
            tick();
            obs   = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
            exp_v = {1'b1, 1'b1, idxs[i], 4'b0001 << idxs[i]};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %b want %b", i, obs, exp_v);
            end
            tick();
            $display("test_wrap_skip: req=%b idx=%0d", reqs[i], idxs[i]);
        end
        req_valid_i = 4'b0000;
        hs_ready_i  = 1'b0;
    endtask

    task automatic test_midop_reset();
        do_reset();
        req_valid_i = 4'b0010;
        hs_ready_i  = 1'b1;
        tick();
        tick();
        hs_ready_i = 1'b0;
        tick();
        obs = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
        n_checks++;
        if (obs !== {1'b1, 1'b1, 2'd1, 4'b0000}) begin
            n_fail++;
            $display("FAIL midrst_locked: got %b want 11010000", obs);
        end
        rst_ni = 1'b0;
        #2;
        obs = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
        n_checks++;
        if (obs !== 8'b0000_0000) begin
            n_fail++;
            $display("FAIL midrst_clear: got %b want 00000000", obs);
        end
        req_valid_i = 4'b1111;
        #1;
        rst_ni = 1'b1;
        tick();
        obs = {hs_valid_o, busy_o, hs_idx_o, req_ready_o};
        n_checks++;
        if (obs !== {1'b1, 1'b1, 2'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL midrst_ptr0: got %b want 11000000", obs);
        end
        hs_ready_i = 1'b1;
        tick();
        req_valid_i = 4'b0000;
        hs_ready_i  = 1'b0;
        $display("test_midop_reset: cleared, regrant idx 0");
    endtask

    task automatic test_timeout();
        do_reset();
        req_valid_i = 4'b0001;
        hs_ready_i  = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
`ifdef ISO_HS_ARB_TIMEOUT_EN
        n_checks++;
        if (timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: got %b want 0", timeout_o);
        end
        tick();
        n_checks++;
        if (timeout_o !== 1'b1 || hs_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL to_set: got to=%b valid=%b want to=1 valid=1", timeout_o, hs_valid_o);
        end
        hs_ready_i = 1'b1;
        tick();
        req_valid_i = 4'b0000;
        hs_ready_i  = 1'b0;
        tick();
        n_checks++;
        if (timeout_o !== 1'b1) begin
            n_fail++;
            $display("FAIL to_sticky: got %b want 1", timeout_o);
        end
        do_reset();
        n_checks++;
        if (timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_reset: got %b want 0", timeout_o);
        end
`else
        tick();
        tick();
        n_checks++;
        if (timeout_o !== 1'b0 || hs_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL to_off: got to=%b valid=%b want to=0 valid=1", timeout_o, hs_valid_o);
        end
        hs_ready_i = 1'b1;
        tick();
        req_valid_i = 4'b0000;
        hs_ready_i  = 1'b0;
`endif
        $display("test_timeout: timeout_o=%b", timeout_o);
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 4'b0000;
        hs_ready_i  = 1'b0;
        test_reset();
        test_rr_fairness();
        test_backpressure();
        test_wrap_skip();
        test_midop_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
